sb_issue_ctrl: RTL and testbench
================================

SB_ISSUE_CTRL -- requirements
Module: sb_issue_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: in_valid  in  1  decoded instruction present.
REQ-004 SHALL provide: in_ready  out  1  block can accept an instruction.
REQ-005 SHALL provide: in_rs, in_rt, in_rd  in  5 each (REG_ADDR)  source and destination registers.
REQ-006 SHALL provide: in_use_rs, in_use_rt, in_wr_rd  in  1 each  operand-use and destination-write flags.
REQ-007 SHALL provide: in_fu  in  3 (FU_ID)  functional-unit tag of the producer.
REQ-008 SHALL provide: issue_valid  out  1  held instruction cleared for dispatch.
REQ-009 SHALL provide: issue_ready  in  1  downstream accepts.
REQ-010 SHALL provide: issue_rs/rt/rd/use_rs/use_rt/wr_rd/fu  out  registered copies of the held instruction.
REQ-011 SHALL provide: wb_valid  in  1  writeback-clear request.
REQ-012 SHALL provide: wb_ready  out  1  clear buffer is empty.
REQ-013 SHALL provide: wb_addr  in  5  register being written back.
REQ-014 SHALL provide: wb_fu  in  3  tag of the retiring unit.
REQ-015 SHALL provide: sb_write_ena  out  1  scoreboard write enable.
REQ-016 SHALL provide: sb_addr  out  5  scoreboard read/write address.
REQ-017 SHALL provide: sb_data_in  out  SCORE_BOARD_DATA  scoreboard write data.
REQ-018 SHALL provide: sb_data_out  in  SCORE_BOARD_DATA  combinational scoreboard read data at sb_addr.

Function
REQ-019 FSM states SHALL be IDLE, CHK_RS, CHK_RT, CHK_RD, SET, ISSUE; in_ready=1 only in IDLE.
REQ-020 IDLE: on in_valid&&in_ready, latch the instruction; next state CHK_RS.
REQ-021 Each CHK state SHALL last one cycle, drive sb_addr with its register, and fail when sb_data_out.busy=1.
REQ-022 A check SHALL pass without a read when its use flag is 0 or its register is 0.
REQ-023 Any failed check SHALL return the FSM to CHK_RS next cycle (re-poll until clear); CHK_RS->CHK_RT->CHK_RD->SET on pass.
REQ-024 SET: if wr_rd and rd!=0, write {busy=1, fu_id=fu} to rd; otherwise no write; next state ISSUE.
REQ-025 ISSUE: issue_valid=1 with payload stable; on issue_ready return to IDLE; in_ready is 0 that cycle.
REQ-026 No-contention latency SHALL be fixed: accept at cycle T, issue_valid first high at T+5.
REQ-027 wb_ready=!wb_pending; an accepted clear is stored in a one-deep buffer.
REQ-028 A pending clear SHALL execute in one cycle as a read-modify-write at sb_addr=wb_addr.
REQ-029 The clear SHALL write {busy=0, fu_id=0} only when busy=1 and fu_id==wb_fu; otherwise the entry is untouched. The buffer empties either way.
REQ-030 A pending clear SHALL have priority for the port: CHK_* or SET holds its state that cycle (no check result, no write); in IDLE/ISSUE it runs in parallel.
REQ-031 A clear accepted at cycle T SHALL execute at T+1 at the earliest; wb_valid while pending is ignored (wb_ready=0).
REQ-032 Writes to register 0 SHALL never be issued.

Reset
REQ-033 While rst=1: state=IDLE, held instruction and wb buffer discarded, sb_write_ena=0, issue_valid=0, in_ready=0, wb_ready=0, sb_addr=0.
REQ-034 First cycle after rst deasserts: in_ready=1, wb_ready=1; reset mid-operation SHALL drop the in-flight instruction with no scoreboard write.

Configuration
REQ-035 Macro SB_WAW_CHECK_EN defined: CHK_RD checks rd busy when wr_rd=1 (WAW stall).
REQ-036 Macro SB_WAW_CHECK_EN undefined: CHK_RD always passes (cycle kept, latency unchanged); SET overwrites the tag; the tag-match clear keeps the newest producer busy.

Structure
REQ-037 REG_ADDR, FU_ID, SCORE_BOARD_DATA {busy, fu_id}, and the FSM state enum SHALL live in the shared package/defines.
REQ-038 No sub-module: the scoreboard RAM is a separate sibling instance wired at the stage top.

Verification
REQ-039 Empty board; issue rs=1, rt=2, rd=3, fu=2, accepted at T -> issue_valid at T+5; entry 3 = {1,2}.
REQ-040 Entry 5 busy; instruction uses rs=5 -> loops CHK_RS; wb 5/tag match -> issue_valid 5 cycles after the clear.
REQ-041 Entry 7 = {1,4}; wb addr=7, fu=1 -> entry unchanged; wb fu=4 -> entry {0,0}.
REQ-042 Clear pending during CHK_RT -> FSM holds one extra cycle; issue at T+6.
REQ-043 rd=0, wr_rd=1 -> no sb_write_ena in SET; rst during CHK_RD -> no issue, all outputs at reset values.
REQ-044 rd=3 busy: SB_WAW_CHECK_EN defined -> stall; undefined -> issue at T+5 and tag overwritten.

Source files
------------

// File: rtl/sb_issue_ctrl_pkg.sv
// Shared types for the scoreboard issue controller: register/tag widths,
// scoreboard entry layout and the controller state encoding.
package sb_issue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FU_ID_W    = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [FU_ID_W-1:0]    fu_id_t;

  typedef struct packed {
    logic   busy;
    fu_id_t fu_id;
  } sb_data_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHK_RS = 3'd1,
    CHK_RT = 3'd2,
    CHK_RD = 3'd3,
    SET    = 3'd4,
    ISSUE  = 3'd5
  } state_t;

  // A register only needs a scoreboard lookup when it is used and is not r0.
  function automatic logic needs_check(input logic use_flag, input reg_addr_t addr);
    return use_flag && (addr != '0);
  endfunction

endpackage

// File: rtl/sb_issue_ctrl.sv
// Scoreboard issue controller: holds one decoded instruction, polls the
// external scoreboard RAM for operand hazards one register per cycle, marks
// the destination busy and then offers the instruction for dispatch.
// Writeback clears arrive through a one-deep buffer and take the RAM port
// ahead of the hazard checks.
//
// Optional feature macro: SB_WAW_CHECK_EN
//   defined   -> CHK_RD stalls while the destination is still busy (WAW)
//   undefined -> CHK_RD always passes; SET overwrites the producer tag
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no instruction held; in_ready=1
// CHK_RS | look up rs; busy -> stay in CHK_RS
// CHK_RT | look up rt; busy -> back to CHK_RS
// CHK_RD | look up rd (WAW build only); busy -> back to CHK_RS
// SET    | write {busy=1, fu} to rd when it is a real destination
// ISSUE  | issue_valid=1, wait for issue_ready
module sb_issue_ctrl
  import sb_issue_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,

  input  logic      in_valid,
  output logic      in_ready,
  input  reg_addr_t in_rs,
  input  reg_addr_t in_rt,
  input  reg_addr_t in_rd,
  input  logic      in_use_rs,
  input  logic      in_use_rt,
  input  logic      in_wr_rd,
  input  fu_id_t    in_fu,

  output logic      issue_valid,
  input  logic      issue_ready,
  output reg_addr_t issue_rs,
  output reg_addr_t issue_rt,
  output reg_addr_t issue_rd,
  output logic      issue_use_rs,
  output logic      issue_use_rt,
  output logic      issue_wr_rd,
  output fu_id_t    issue_fu,

  input  logic      wb_valid,
  output logic      wb_ready,
  input  reg_addr_t wb_addr,
  input  fu_id_t    wb_fu,

  output logic      sb_write_ena,
  output reg_addr_t sb_addr,
  output sb_data_t  sb_data_in,
  input  sb_data_t  sb_data_out
);

  state_t    state;

  reg_addr_t h_rs;
  reg_addr_t h_rt;
  reg_addr_t h_rd;
  logic      h_use_rs;
  logic      h_use_rt;
  logic      h_wr_rd;
  fu_id_t    h_fu;

  logic      wb_pending;
  reg_addr_t wb_addr_q;
  fu_id_t    wb_fu_q;

  logic      chk_pass;
  logic      clr_hit;

  // Handshake readiness; both drop while reset is asserted.
  assign in_ready = !rst && (state == IDLE);
  assign wb_ready = !rst && !wb_pending;

  // The held instruction registers double as the dispatch payload.
  assign issue_rs     = h_rs;
  assign issue_rt     = h_rt;
  assign issue_rd     = h_rd;
  assign issue_use_rs = h_use_rs;
  assign issue_use_rt = h_use_rt;
  assign issue_wr_rd  = h_wr_rd;
  assign issue_fu     = h_fu;

  // Only clear the entry if the retiring unit is still its recorded producer,
  // so a newer producer that overwrote the tag stays busy.
  assign clr_hit = wb_pending && sb_data_out.busy && (sb_data_out.fu_id == wb_fu_q);

  // Scoreboard port arbitration: a pending clear owns the port, otherwise the
  // current FSM state selects the register to read or write.
  always_comb begin
    sb_addr      = '0;
    sb_write_ena = 1'b0;
    sb_data_in   = '0;
    chk_pass     = 1'b1;
    if (!rst) begin
      if (wb_pending) begin
        sb_addr      = wb_addr_q;
        sb_write_ena = clr_hit;
      end else begin
        case (state)
          CHK_RS: begin
            sb_addr  = h_rs;
            chk_pass = !(needs_check(h_use_rs, h_rs) && sb_data_out.busy);
          end
          CHK_RT: begin
            sb_addr  = h_rt;
            chk_pass = !(needs_check(h_use_rt, h_rt) && sb_data_out.busy);
          end
          CHK_RD: begin
            sb_addr  = h_rd;
`ifdef SB_WAW_CHECK_EN
            chk_pass = !(needs_check(h_wr_rd, h_rd) && sb_data_out.busy);
`else
            chk_pass = 1'b1;
`endif
          end
          SET: begin
            sb_addr = h_rd;
            if (needs_check(h_wr_rd, h_rd)) begin
              sb_write_ena     = 1'b1;
              sb_data_in.busy  = 1'b1;
              sb_data_in.fu_id = h_fu;
            end
          end
          default: begin
            sb_addr = '0;
          end
        endcase
      end
    end
  end

  // Issue FSM; CHK_* and SET freeze for any cycle in which a clear holds the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_valid <= 1'b0;
      h_rs        <= '0;
      h_rt        <= '0;
      h_rd        <= '0;
      h_use_rs    <= 1'b0;
      h_use_rt    <= 1'b0;
      h_wr_rd     <= 1'b0;
      h_fu        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            h_rs     <= in_rs;
            h_rt     <= in_rt;
            h_rd     <= in_rd;
            h_use_rs <= in_use_rs;
            h_use_rt <= in_use_rt;
            h_wr_rd  <= in_wr_rd;
            h_fu     <= in_fu;
            state    <= CHK_RS;
          end
        end
        CHK_RS: begin
          if (!wb_pending) state <= chk_pass ? CHK_RT : CHK_RS;
        end
        CHK_RT: begin
          if (!wb_pending) state <= chk_pass ? CHK_RD : CHK_RS;
        end
        CHK_RD: begin
          if (!wb_pending) state <= chk_pass ? SET : CHK_RS;
        end
        SET: begin
          if (!wb_pending) begin
            state       <= ISSUE;
            issue_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            state       <= IDLE;
            issue_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          issue_valid <= 1'b0;
        end
      endcase
    end
  end

  // One-deep writeback-clear buffer; a pending clear always executes in the
  // following cycle, so the buffer empties after exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_pending <= 1'b0;
      wb_addr_q  <= '0;
      wb_fu_q    <= '0;
    end else if (wb_pending) begin
      wb_pending <= 1'b0;
    end else if (wb_valid) begin
      wb_pending <= 1'b1;
      wb_addr_q  <= wb_addr;
      wb_fu_q    <= wb_fu;
    end
  end

endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Self-checking bench for sb_issue_ctrl. The scoreboard RAM lives here as a
// sibling of the controller; a separate array holds the expected board
// contents derived from the issue/clear rules.
module tb_sb_issue_ctrl;
  import sb_issue_ctrl_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      in_valid = 1'b0;
  logic      in_ready;
  reg_addr_t in_rs = '0, in_rt = '0, in_rd = '0;
  logic      in_use_rs = 1'b0, in_use_rt = 1'b0, in_wr_rd = 1'b0;
  fu_id_t    in_fu = '0;
  logic      issue_valid;
  logic      issue_ready = 1'b1;
  reg_addr_t issue_rs, issue_rt, issue_rd;
  logic      issue_use_rs, issue_use_rt, issue_wr_rd;
  fu_id_t    issue_fu;
  logic      wb_valid = 1'b0;
  logic      wb_ready;
  reg_addr_t wb_addr = '0;
  fu_id_t    wb_fu = '0;
  logic      sb_write_ena;
  reg_addr_t sb_addr;
  sb_data_t  sb_data_in;
  sb_data_t  sb_data_out;

  always #5 clk = ~clk;

  sb_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_wr_rd(in_wr_rd), .in_fu(in_fu),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wr_rd(issue_wr_rd), .issue_fu(issue_fu),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_fu(wb_fu),
    .sb_write_ena(sb_write_ena), .sb_addr(sb_addr),
    .sb_data_in(sb_data_in), .sb_data_out(sb_data_out)
  );

  // Scoreboard RAM: combinational read, write at the clock edge; the bench
  // preloads entries through its own port while the controller is idle.
  sb_data_t    sb_mem [32] = '{default: '0};
  logic        pl_en = 1'b0;
  reg_addr_t   pl_addr = '0;
  sb_data_t    pl_data = '0;
  int unsigned wr_cnt = 0;
  int unsigned wr0_cnt = 0;

  assign sb_data_out = sb_mem[sb_addr];

  always @(posedge clk) begin
    if (pl_en) sb_mem[pl_addr] <= pl_data;
    else if (sb_write_ena) sb_mem[sb_addr] <= sb_data_in;
    if (sb_write_ena) begin
      wr_cnt <= wr_cnt + 1;
      if (sb_addr == '0) wr0_cnt <= wr0_cnt + 1;
    end
  end

  // Expected board contents and the instruction currently in flight.
  sb_data_t  ref_sb [32];
  reg_addr_t e_rs, e_rt, e_rd;
  logic      e_urs, e_urt, e_wrd;
  fu_id_t    e_fu;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input bit b, input int f);
    pl_en        = 1'b1;
    pl_addr      = reg_addr_t'(a);
    pl_data.busy = b;
    pl_data.fu_id = fu_id_t'(f);
    tick();
    pl_en = 1'b0;
    ref_sb[a] = pl_data;
  endtask

  task automatic check_board(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(sb_mem[i]), 32'(ref_sb[i]));
  endtask

  task automatic drive_instr(input int rs, input int rt, input int rd,
                             input bit urs, input bit urt, input bit wrd, input int fu);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 1);
    e_rs = reg_addr_t'(rs); e_rt = reg_addr_t'(rt); e_rd = reg_addr_t'(rd);
    e_urs = urs; e_urt = urt; e_wrd = wrd; e_fu = fu_id_t'(fu);
    in_rs = e_rs; in_rt = e_rt; in_rd = e_rd;
    in_use_rs = e_urs; in_use_rt = e_urt; in_wr_rd = e_wrd; in_fu = e_fu;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_issue(input int budget, output int k);
    k = 0;
    while (issue_valid !== 1'b1 && k < budget) begin tick(); k++; end
  endtask

  task automatic check_payload(input string tag);
    chk({tag, "_rs"}, 32'(issue_rs), 32'(e_rs));
    chk({tag, "_rt"}, 32'(issue_rt), 32'(e_rt));
    chk({tag, "_rd"}, 32'(issue_rd), 32'(e_rd));
    chk({tag, "_flags"}, {29'b0, issue_use_rs, issue_use_rt, issue_wr_rd}, {29'b0, e_urs, e_urt, e_wrd});
    chk({tag, "_fu"}, 32'(issue_fu), 32'(e_fu));
  endtask

  function automatic bit predict_stall();
    bit s = 1'b0;
    if (e_urs && e_rs != 0 && ref_sb[e_rs].busy) s = 1'b1;
    if (e_urt && e_rt != 0 && ref_sb[e_rt].busy) s = 1'b1;
`ifdef SB_WAW_CHECK_EN
    if (e_wrd && e_rd != 0 && ref_sb[e_rd].busy) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic void apply_issue();
    if (e_wrd && e_rd != 0) begin
      ref_sb[e_rd].busy  = 1'b1;
      ref_sb[e_rd].fu_id = e_fu;
    end
  endfunction

  function automatic void apply_clear(input int a, input int f);
    if (ref_sb[a].busy && ref_sb[a].fu_id == fu_id_t'(f)) ref_sb[a] = '0;
  endfunction

  task automatic send_wb(input int a, input int f);
    int n = 0;
    while (wb_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) chk("wb_ready_timeout", 32'(wb_ready), 1);
    wb_addr = reg_addr_t'(a); wb_fu = fu_id_t'(f); wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    apply_clear(a, f);
  endtask

  task automatic no_issue_for(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin tick(); if (issue_valid === 1'b1) seen = 1'b1; end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    int k, k2;
    int wr_before;
    for (int i = 0; i < 32; i++) ref_sb[i] = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wb_ready", 32'(wb_ready), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_sb_we", 32'(sb_write_ena), 0);
    chk("rst_sb_addr", 32'(sb_addr), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_wb_ready", 32'(wb_ready), 1);

    // Basic issue on an empty board, with downstream back-pressure
    drive_instr(1, 2, 3, 1, 1, 1, 2);
    issue_ready = 1'b0;
    wait_issue(20, k);
    chk("basic_latency", 32'(k), 4);
    chk("basic_in_ready_issue", 32'(in_ready), 0);
    check_payload("basic");
    repeat (2) tick();
    chk("basic_hold_valid", 32'(issue_valid), 1);
    check_payload("basic_hold");
    apply_issue();
    issue_ready = 1'b1;
    tick();
    chk("basic_done_valid", 32'(issue_valid), 0);
    chk("basic_done_in_ready", 32'(in_ready), 1);
    check_board("basic_board");

    // Tag-matched clear only
    preload(7, 1, 4);
    send_wb(7, 1);
    tick();
    check_board("wb_mismatch");
    send_wb(7, 4);
    tick();
    check_board("wb_match");

    // RAW stall on rs, released by a writeback clear
    preload(5, 1, 3);
    drive_instr(5, 0, 6, 1, 0, 1, 1);
    no_issue_for("raw_stall", 8);
    send_wb(5, 3);
    wait_issue(20, k);
    chk("raw_release_latency", 32'(k), 5);
    check_payload("raw");
    apply_issue();
    tick();
    check_board("raw_board");

    // A clear pending during CHK_RT costs one cycle
    drive_instr(1, 2, 4, 1, 1, 1, 3);
    wb_addr = 5'd10; wb_fu = 3'd0; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    apply_clear(10, 0);
    wait_issue(20, k2);
    chk("clr_hold_latency", 32'(1 + k2), 5);
    apply_issue();
    tick();
    check_board("clr_hold_board");

    // Destination r0 is never written
    wr_before = int'(wr_cnt);
    drive_instr(1, 2, 0, 1, 1, 1, 6);
    wait_issue(20, k);
    chk("r0_latency", 32'(k), 4);
    tick();
    chk("r0_no_write", wr_cnt - wr_before, 0);

    // Busy destination
    preload(3, 1, 5);
    drive_instr(1, 2, 3, 1, 1, 1, 6);
`ifdef SB_WAW_CHECK_EN
    no_issue_for("waw_stall", 8);
    send_wb(3, 5);
    wait_issue(30, k);
    chk("waw_release", 32'(issue_valid), 1);
`else
    wait_issue(20, k);
    chk("waw_latency", 32'(k), 4);
`endif
    check_payload("waw");
    apply_issue();
    tick();
    tick();
    check_board("waw_board");
    send_wb(3, 5);
    tick();
    check_board("waw_old_tag_clear");

    // Reset while in CHK_RD drops the instruction
    wr_before = int'(wr_cnt);
    drive_instr(1, 2, 9, 1, 1, 1, 5);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_we_comb", 32'(sb_write_ena), 0);
    tick();
    chk("mid_rst_issue_valid", 32'(issue_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_wb_ready", 32'(wb_ready), 0);
    chk("mid_rst_sb_addr", 32'(sb_addr), 0);
    chk("mid_rst_sb_we", 32'(sb_write_ena), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_post_in_ready", 32'(in_ready), 1);
    chk("mid_rst_post_wb_ready", 32'(wb_ready), 1);
    no_issue_for("mid_rst_no_issue", 8);
    chk("mid_rst_no_write", wr_cnt - wr_before, 0);
    check_board("mid_rst_board");

    // Randomized instructions against the board model
    for (int it = 0; it < 16; it++) begin
      for (int p = 0; p < 2; p++)
        preload(int'($urandom_range(1, 7)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      drive_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
      if (!predict_stall()) begin
        wait_issue(20, k);
        chk("rnd_latency", 32'(k), 4);
        check_payload("rnd");
        apply_issue();
        tick();
      end else begin
        issue_ready = 1'b0;
        no_issue_for("rnd_stall", 6);
        if (e_urs && e_rs != 0 && ref_sb[e_rs].busy) send_wb(int'(e_rs), int'(ref_sb[e_rs].fu_id));
        if (e_urt && e_rt != 0 && ref_sb[e_rt].busy) send_wb(int'(e_rt), int'(ref_sb[e_rt].fu_id));
`ifdef SB_WAW_CHECK_EN
        if (e_wrd && e_rd != 0 && ref_sb[e_rd].busy) send_wb(int'(e_rd), int'(ref_sb[e_rd].fu_id));
`endif
        wait_issue(40, k);
        chk("rnd_release", 32'(issue_valid), 1);
        check_payload("rnd_rel");
        apply_issue();
        issue_ready = 1'b1;
        tick();
      end
      tick();
      check_board("rnd_board");
      send_wb(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)));
      tick();
      check_board("rnd_wb_board");
    end

    chk("never_write_r0", wr0_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
